// File: rtl/accum_drv_pkg.sv
// Shared types and defaults for the accumulator stimulus driver.
// The state enum and the counter-width helper are used by accum_driver and stim_mem.
package accum_drv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RST  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } drv_state_e;

    localparam int DEF_WIDTH        = 32;
    localparam int DEF_DEPTH        = 256;
    localparam int DEF_RESET_CYCLES = 3;

    // Bits needed to hold the values 0..n of a down-counter.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage : accum_drv_pkg

// File: rtl/stim_mem.sv
// Vector store for the driver: one synchronous write port and one asynchronous read port.
// A same-cycle write and read of one address returns the old word.
module stim_mem
    import accum_drv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clock,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // NOTE: the array has no reset, so it maps onto plain RAM and survives a design reset.
    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : stim_mem

// File: rtl/accum_driver.sv
// Sequencer upstream of the accumulator: it resets the accumulator, streams the vector store
// on its in/en inputs and tracks the golden running sum for a downstream checker.
module accum_driver
    import accum_drv_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int DEPTH        = DEF_DEPTH,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     i_start,
    input  logic                     i_hold,
    input  logic                     i_load_en,
    input  logic [$clog2(DEPTH)-1:0] i_load_addr,
    input  logic [WIDTH-1:0]         i_load_data,
    output logic                     o_dut_reset,
    output logic                     o_dut_en,
    output logic [WIDTH-1:0]         o_dut_in,
    output logic [WIDTH-1:0]         o_gold_sum,
    output logic [$clog2(DEPTH):0]   o_issued,
    output logic                     o_busy,
    output logic                     o_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int IW = AW + 1;
    localparam int CW = cnt_width(RESET_CYCLES);

    drv_state_e      r_state;
    drv_state_e      w_state_next;
    logic [CW-1:0]   r_rst_cnt;
    logic [AW-1:0]   r_idx;
    logic [WIDTH-1:0] r_gold_sum;
    logic [IW-1:0]   r_issued;

    logic [WIDTH-1:0] w_mem_rdata;
    logic             w_mem_we;
    logic             w_fire;
    logic             w_last;
    logic             w_rst_end;

    // The store is only writable while no run is in flight.
    assign w_mem_we  = i_load_en && ((r_state == IDLE) || (r_state == DONE));
    assign w_fire    = o_dut_en;
    assign w_last    = (r_idx == AW'(DEPTH - 1));
    assign w_rst_end = (r_rst_cnt == CW'(1));

    stim_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_stim_mem (
        .clock   (clock),
        .i_we    (w_mem_we),
        .i_waddr (i_load_addr),
        .i_wdata (i_load_data),
        .i_raddr (r_idx),
        .o_rdata (w_mem_rdata)
    );

    // NOTE: sequential state is assigned with non-blocking <= so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (i_start)            w_state_next = RST;
            RST:     if (w_rst_end)          w_state_next = RUN;
            RUN:     if (w_fire && w_last)   w_state_next = DONE;
            DONE:    if (i_start)            w_state_next = RST;
            default:                         w_state_next = IDLE;
        endcase
    end

    always_comb begin
        o_dut_reset = 1'b0;
        o_dut_en    = 1'b0;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        unique case (r_state)
            RST: begin
                o_dut_reset = 1'b1;
                o_busy      = 1'b1;
            end
            RUN: begin
                o_dut_en = !i_hold;
                o_busy   = 1'b1;
            end
            DONE:    o_done = 1'b1;
            default: ;
        endcase
    end

    // Run counters and golden sum; the sum is cleared on the RST->RUN edge so it lines up
    // with an accumulator that was reset during RST and has not yet been enabled.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rst_cnt  <= '0;
            r_idx      <= '0;
            r_gold_sum <= '0;
            r_issued   <= '0;
        end else begin
            unique case (r_state)
                IDLE, DONE: begin
                    if (i_start) begin
                        r_rst_cnt <= CW'(RESET_CYCLES);
                    end
                end
                RST: begin
                    r_rst_cnt <= r_rst_cnt - CW'(1);
                    if (w_rst_end) begin
                        r_idx      <= '0;
                        r_gold_sum <= '0;
                        r_issued   <= '0;
                    end
                end
                RUN: begin
                    if (w_fire) begin
                        r_idx      <= w_last ? '0 : r_idx + AW'(1);
                        r_gold_sum <= r_gold_sum + w_mem_rdata;
                        r_issued   <= r_issued + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_dut_in   = w_mem_rdata;
    assign o_gold_sum = r_gold_sum;
    assign o_issued   = r_issued;

endmodule : accum_driver

// File: tb/tb_accum_driver.sv
// Bench for accum_driver at DEPTH=4: a table of load/hold runs plus hand-written reset,
// late-load and start-while-busy sequences, with a scoreboard on the issued stream.
module tb_accum_driver;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int RC    = 3;

    logic             clock = 1'b0;
    logic             reset;
    logic             i_start;
    logic             i_hold;
    logic             i_load_en;
    logic [1:0]       i_load_addr;
    logic [WIDTH-1:0] i_load_data;
    logic             o_dut_reset;
    logic             o_dut_en;
    logic [WIDTH-1:0] o_dut_in;
    logic [WIDTH-1:0] o_gold_sum;
    logic [2:0]       o_issued;
    logic             o_busy;
    logic             o_done;

    accum_driver #(
        .WIDTH        (WIDTH),
        .DEPTH        (DEPTH),
        .RESET_CYCLES (RC)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .i_start     (i_start),
        .i_hold      (i_hold),
        .i_load_en   (i_load_en),
        .i_load_addr (i_load_addr),
        .i_load_data (i_load_data),
        .o_dut_reset (o_dut_reset),
        .o_dut_en    (o_dut_en),
        .o_dut_in    (o_dut_in),
        .o_gold_sum  (o_gold_sum),
        .o_issued    (o_issued),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0][WIDTH-1:0] d;
        int                    hold_at;
        int                    hold_len;
        logic [WIDTH-1:0]      exp_sum;
    } vec_t;

    vec_t             tbl [4];
    logic [WIDTH-1:0] sb [$];
    logic [WIDTH-1:0] acc;
    int               n_tests = 0;
    int               n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Downstream accumulator: register-after-add with synchronous reset.
    always @(posedge clock) begin
        if (o_dut_reset)   acc <= '0;
        else if (o_dut_en) acc <= acc + o_dut_in;
    end

    // Every enabled cycle must carry the next expected vector.
    always @(negedge clock) begin
        if (o_dut_en === 1'b1) begin
            if (sb.size() == 0) check("sb_underflow", 64'(o_dut_in), 64'hDEAD);
            else                check("sb_data", 64'(o_dut_in), 64'(sb.pop_front()));
        end
    end

    task automatic run_vec(input vec_t v, input bit do_load, input bit load_in_run, input bit start_in_run);
        int               idx;
        int               held;
        int               cyc;
        bit               en;
        logic [WIDTH-1:0] sum;
        if (do_load) begin
            for (int i = 0; i < 4; i++) begin
                i_load_en   = 1'b1;
                i_load_addr = 2'(i);
                i_load_data = v.d[i];
                tick();
            end
        end
        i_load_en = 1'b0;
        for (int i = 0; i < 4; i++) sb.push_back(v.d[i]);
        i_start = 1'b1;
        tick();
        if (!start_in_run) i_start = 1'b0;
        for (int c = 0; c < RC; c++) begin
            i_hold = 1'b1;
            check("rst_high", 64'(o_dut_reset), 64'd1);
            check("rst_busy", 64'(o_busy), 64'd1);
            tick();
        end
        i_hold = 1'b0;
        check("rst_low", 64'(o_dut_reset), 64'd0);
        idx  = 0;
        held = 0;
        sum  = '0;
        cyc  = 0;
        while (idx < 4 && cyc < 20) begin
            en = !(idx == v.hold_at && held < v.hold_len);
            if (!en) held++;
            i_hold      = !en;
            i_load_en   = load_in_run && (cyc == 1);
            i_load_addr = 2'd0;
            i_load_data = 32'd99;
            #1;
            check("run_en", 64'(o_dut_en), 64'(en));
            check("run_in", 64'(o_dut_in), 64'(v.d[idx]));
            check("run_gold", 64'(o_gold_sum), 64'(sum));
            check("run_issued", 64'(o_issued), 64'(idx));
            check("run_done", 64'(o_done), 64'd0);
            if (en) begin
                sum = sum + v.d[idx];
                idx++;
            end
            cyc++;
            tick();
        end
        i_hold    = 1'b0;
        i_load_en = 1'b0;
        i_start   = 1'b0;
        check("end_idx", 64'(idx), 64'd4);
        check("end_cycles", 64'(cyc), 64'(4 + v.hold_len));
        check("end_done", 64'(o_done), 64'd1);
        check("end_busy", 64'(o_busy), 64'd0);
        check("end_en", 64'(o_dut_en), 64'd0);
        check("end_gold", 64'(o_gold_sum), 64'(v.exp_sum));
        check("end_issued", 64'(o_issued), 64'd4);
        check("end_acc", 64'(acc), 64'(v.exp_sum));
        check("end_sb_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        tbl[0] = '{d: '{32'd4, 32'd3, 32'd2, 32'd1}, hold_at: 7, hold_len: 0, exp_sum: 32'd10};
        tbl[1] = '{d: '{32'd4, 32'd3, 32'd2, 32'd1}, hold_at: 2, hold_len: 2, exp_sum: 32'd10};
        tbl[2] = '{d: '{32'd0, 32'd0, 32'd2, 32'hFFFF_FFFF}, hold_at: 7, hold_len: 0, exp_sum: 32'd1};
        tbl[3] = '{d: '{32'd7, 32'd5, 32'h8000_0000, 32'h8000_0000}, hold_at: 0, hold_len: 1, exp_sum: 32'd12};

        reset       = 1'b1;
        i_start     = 1'b0;
        i_hold      = 1'b0;
        i_load_en   = 1'b0;
        i_load_addr = '0;
        i_load_data = '0;
        repeat (2) tick();
        check("rst_state_dut_reset", 64'(o_dut_reset), 64'd0);
        check("rst_state_dut_en", 64'(o_dut_en), 64'd0);
        check("rst_state_gold", 64'(o_gold_sum), 64'd0);
        check("rst_state_issued", 64'(o_issued), 64'd0);
        check("rst_state_busy", 64'(o_busy), 64'd0);
        check("rst_state_done", 64'(o_done), 64'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) run_vec(tbl[i], 1'b1, 1'b0, 1'b0);

        // Writes during RUN are dropped; start held through RST/RUN is ignored.
        run_vec(tbl[0], 1'b1, 1'b1, 1'b1);
        run_vec(tbl[0], 1'b0, 1'b0, 1'b0);

        // Final values hold in DONE.
        repeat (2) tick();
        check("done_hold_gold", 64'(o_gold_sum), 64'd10);
        check("done_hold_issued", 64'(o_issued), 64'd4);
        check("done_hold_done", 64'(o_done), 64'd1);

        // Reset mid-RUN at idx 2, then replay from the first vector.
        for (int i = 0; i < 4; i++) sb.push_back(tbl[0].d[i]);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (RC + 2) tick();
        check("mid_run_in", 64'(o_dut_in), 64'd3);
        check("mid_run_issued", 64'(o_issued), 64'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        check("mid_reset_busy", 64'(o_busy), 64'd0);
        check("mid_reset_done", 64'(o_done), 64'd0);
        check("mid_reset_en", 64'(o_dut_en), 64'd0);
        check("mid_reset_gold", 64'(o_gold_sum), 64'd0);
        check("mid_reset_issued", 64'(o_issued), 64'd0);
        check("mid_reset_in", 64'(o_dut_in), 64'd1);
        run_vec(tbl[0], 1'b0, 1'b0, 1'b0);

        // Reset while the accumulator reset sequence is in progress.
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("rst_seq_active", 64'(o_dut_reset), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_seq_abort", 64'(o_dut_reset), 64'd0);
        check("rst_seq_busy", 64'(o_busy), 64'd0);
        tick();
        check("rst_seq_idle", 64'(o_busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1);
    end

endmodule : tb_accum_driver

// File: doc/accum_driver.md
# accum_driver

Stimulus sequencer that sits directly upstream of the accumulator stage. It holds a preloadable vector memory and issues a reset sequence to the downstream accumulator. It then streams one vector per enabled cycle onto the accumulator's `in`/`en` inputs and keeps a golden running sum, so a downstream checker can compare it against the accumulator output.

## Interface
- `WIDTH`, 32, data width of vectors, `dut_in` and `gold_sum`
- `DEPTH`, 256, number of vectors; legal range ≥ 2
- `RESET_CYCLES`, 3, cycles `dut_reset` is held high per run; legal range ≥ 1
- `clock`  in  1  clock
- `reset`  in  1  reset; synchronous, active-high
- `start`  in  1  begin a run; sampled only in IDLE or DONE
- `hold`  in  1  stall the stream while in RUN
- `load_en`  in  1  vector memory write strobe
- `load_addr`  in  $clog2(DEPTH)  vector memory write address
- `load_data`  in  WIDTH  vector memory write data
- `dut_reset`  out  1  drives the accumulator's `reset`
- `dut_en`  out  1  drives the accumulator's `en`
- `dut_in`  out  WIDTH  drives the accumulator's `in`
- `gold_sum`  out  WIDTH  expected accumulator value for the current cycle
- `issued`  out  $clog2(DEPTH)+1  count of vectors issued in this run
- `busy`  out  1  high in RST or RUN
- `done`  out  1  high in DONE

## Operation
- FSM states: IDLE, RST, RUN, DONE.
- IDLE → RST on `start`. `rst_cnt` is loaded with RESET_CYCLES.
- RST: `rst_cnt` decrements each cycle. When `rst_cnt` reaches 1 → RUN, with `idx` = 0, `gold_sum` = 0 and `issued` = 0. `hold` and `start` are ignored in RST.
- RUN:
  - `dut_en` = !`hold`; `dut_in` = mem[`idx`].
  - On each cycle with `dut_en` high: `idx`++, `issued`++, and `gold_sum` ← `gold_sum` + mem[`idx`], mod 2^WIDTH, wrapping silently.
  - The enabled cycle at `idx` == DEPTH-1 is the last one → DONE.
- DONE: `dut_en` = 0 and `gold_sum`/`issued` hold their final values. `start` → RST and a new run begins; memory is retained.
- `dut_reset` = 1 exactly in RST. `dut_en` = 0 outside RUN. `dut_in` = mem[`idx`] in all states.
- Memory writes:
  - Accepted in IDLE and DONE only; `load_en` in RST or RUN is dropped.
  - Memory is not reset and has no defined initial contents.
- `reset`: all outputs take their reset values on the next edge, including mid-run and mid-RST. Memory is untouched.

## Timing
- Reset values: state IDLE; `dut_reset` 0, `dut_en` 0, `gold_sum` 0, `issued` 0, `busy` 0, `done` 0, `idx` 0.
- `start` sampled at edge t:
  - `dut_reset` high for cycles t+1 … t+RESET_CYCLES.
  - RUN begins at t+RESET_CYCLES+1.
- State, `idx`, `gold_sum` and `issued` are registers. `dut_en` is combinational from state and `hold`. `dut_in` is an asynchronous memory read of the registered `idx`.
- With no `hold`, DONE is entered at t+RESET_CYCLES+DEPTH+1. Each held cycle adds one cycle.
- `gold_sum` in cycle k equals the accumulator's `out` in cycle k, because the accumulator is register-after-add with the same reset timing.
- A load to `idx`'s address in the same cycle it is read: the read returns the old data; the new data is visible next cycle.

## Structure
- Package `accum_drv_pkg`: `drv_state_e` enum {IDLE, RST, RUN, DONE}, default WIDTH/DEPTH localparams.
- Sub-module `stim_mem`: DEPTH×WIDTH, one synchronous write port, one asynchronous read port.
- FSM, counters and golden sum live in `accum_driver`.

## Test plan
- DEPTH=4, load 1,2,3,4, pulse `start` with no hold → `dut_reset` high 3 cycles, then `dut_in` 1,2,3,4 with `dut_en` high; `done` after 4 RUN cycles; `gold_sum`=10; a connected accumulator reads 10.
- Same load, `hold` high for 2 cycles at `idx`=2 → `dut_en` low those 2 cycles, `dut_in` stays 3, DONE 2 cycles later, `gold_sum` still 10.
- Load 0xFFFF_FFFF, 2, 0, 0 → `gold_sum` wraps to 1.
- `reset` asserted during RUN at `idx`=2 → next cycle IDLE, all outputs 0; a new `start` replays from `dut_in`=1.
- `load_en` during RUN (addr 0, data 99) → ignored; second run after DONE still issues 1 first.
- `start` during RST or RUN → no effect; `start` in DONE → fresh RST of 3 cycles, `issued` restarts at 0.
